sysid_check_master: RTL and testbench

- Avalon-MM read master that interrogates the system ID slave: reads ID word (address 0), then timestamp word (address 1).
- Compares both words against build-time expected values and reports pass/fail/timeout.
- Sits beside the boot/config logic; its status gates downstream acquisition start, so a mismatched FPGA image is flagged without the host CPU.

---
 rtl/sysid_check_master.sv | 139 +++++++++++++
 tb/tb_sysid_check_master.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_check_master.sv
// Avalon-MM read master that fetches the system ID and timestamp words and
// compares them against build-time values, reporting pass/fail/timeout.
module sysid_check_master #(
  parameter logic [31:0] EXPECTED_ID        = 32'd925608351,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1316107553,
  parameter bit          CHECK_TIMESTAMP    = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES     = 1024,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] timestamp_value
);

  typedef enum logic [2:0] {
    IDLE,
    ID_REQ,
    ID_WAIT,
    TS_REQ,
    TS_WAIT,
    FIN
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [15:0] to_cnt;
  logic        first_cycle;
  logic        accepted;
  logic        expired;
  logic        launch;

  assign accepted = avm_read && !avm_waitrequest;
  assign expired  = (to_cnt == TO_LAST);
  assign launch   = start || (AUTO_START && first_cycle && (state == IDLE));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      to_cnt          <= '0;
      first_cycle     <= 1'b1;
      avm_address     <= 1'b0;
      avm_read        <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      timeout         <= 1'b0;
      id_value        <= '0;
      timestamp_value <= '0;
    end else begin
      first_cycle <= 1'b0;
      unique case (state)
        IDLE, FIN: begin
          if (launch) begin
            state       <= ID_REQ;
            to_cnt      <= '0;
            avm_address <= 1'b0;
            avm_read    <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
          end
        end
        ID_REQ, TS_REQ: begin
          if (expired) begin
            state    <= FIN;
            avm_read <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            pass     <= 1'b0;
            timeout  <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 16'd1;
            if (accepted) begin
              avm_read <= 1'b0;
              if (state == ID_REQ) state <= ID_WAIT;
              else                 state <= TS_WAIT;
            end
          end
        end
        ID_WAIT: begin
          // Data arriving on the expiry cycle still completes the transaction.
          if (avm_readdatavalid) begin
            id_value    <= avm_readdata;
            state       <= TS_REQ;
            to_cnt      <= '0;
            avm_address <= 1'b1;
            avm_read    <= 1'b1;
          end else if (expired) begin
            state   <= FIN;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= 1'b0;
            timeout <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end
        TS_WAIT: begin
          if (avm_readdatavalid) begin
            timestamp_value <= avm_readdata;
            state           <= FIN;
            busy            <= 1'b0;
            done            <= 1'b1;
            // Compare the live bus word: timestamp_value updates on this same edge.
            pass            <= (id_value == EXPECTED_ID) &&
                               (!CHECK_TIMESTAMP || (avm_readdata == EXPECTED_TIMESTAMP));
          end else if (expired) begin
            state   <= FIN;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= 1'b0;
            timeout <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end
        default: begin
          state    <= IDLE;
          avm_read <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_check_master.sv
// Bench for sysid_check_master: behavioural Avalon slave, scoreboard of
// expected check results, latency and handshake checks.
module tb_sysid_check_master;

  localparam logic [31:0] EXP_ID = 32'd925608351;
  localparam logic [31:0] EXP_TS = 32'd1316107553;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        wr;
  logic [31:0] rdata;
  logic        rdv;

  logic        a_addr, a_read, a_busy, a_done, a_pass, a_timeout;
  logic [31:0] a_id, a_ts;
  logic        b_addr, b_read, b_busy, b_done, b_pass, b_timeout;
  logic [31:0] b_id, b_ts;

  always #5 clk = ~clk;

  sysid_check_master #(.TIMEOUT_CYCLES(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start),
    .avm_address(a_addr), .avm_read(a_read), .avm_waitrequest(wr),
    .avm_readdata(rdata), .avm_readdatavalid(rdv),
    .busy(a_busy), .done(a_done), .pass(a_pass), .timeout(a_timeout),
    .id_value(a_id), .timestamp_value(a_ts)
  );

  sysid_check_master #(.CHECK_TIMESTAMP(1'b0), .TIMEOUT_CYCLES(16)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start),
    .avm_address(b_addr), .avm_read(b_read), .avm_waitrequest(wr),
    .avm_readdata(rdata), .avm_readdatavalid(rdv),
    .busy(b_busy), .done(b_done), .pass(b_pass), .timeout(b_timeout),
    .id_value(b_id), .timestamp_value(b_ts)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] id;
    logic [31:0] ts;
    logic        pa;
    logic        pb;
    logic        to;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_id = '0;
  logic [31:0] last_ts = '0;

  task automatic expect_check(input logic [31:0] id, input logic [31:0] ts, input bit to);
    exp_t e;
    if (to) begin
      e = '{id: last_id, ts: last_ts, pa: 1'b0, pb: 1'b0, to: 1'b1};
    end else begin
      e = '{id: id, ts: ts, pa: (id == EXP_ID) && (ts == EXP_TS), pb: (id == EXP_ID), to: 1'b0};
      last_id = id;
      last_ts = ts;
    end
    sb.push_back(e);
  endtask

  // Slave configuration
  logic [31:0] id_data  = EXP_ID;
  logic [31:0] ts_data  = EXP_TS;
  int unsigned id_wait  = 0;
  int unsigned ts_wait  = 0;
  bit          respond  = 1'b1;
  bit          ts_resp  = 1'b1;
  bit          stale    = 1'b0;
  int unsigned ts_req_cycles = 0;
  logic        acc_log[$];

  bit          pend = 1'b0;
  logic        pend_addr = 1'b0;
  int unsigned wcnt = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      pend = 1'b0; wr = 1'b0; rdv = 1'b0; rdata = '0; wcnt = 0;
    end else begin
      rdv = 1'b0;
      rdata = '0;
      if (pend && respond && (!pend_addr || ts_resp)) begin
        rdv = 1'b1;
        rdata = pend_addr ? ts_data : id_data;
      end
      pend = 1'b0;
      if (a_read) begin
        if (a_addr) ts_req_cycles++;
        if (wcnt < (a_addr ? ts_wait : id_wait)) begin
          wr = 1'b1;
          wcnt++;
          if (stale && !a_addr) begin
            rdv = 1'b1;
            rdata = 32'hDEADBEEF;
            stale = 1'b0;
          end
        end else begin
          wr = 1'b0;
          wcnt = 0;
          pend = 1'b1;
          pend_addr = a_addr;
          acc_log.push_back(a_addr);
        end
      end else begin
        wr = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Scoreboard monitor: compare each completed check against the queue head
  logic done_q = 1'b0;
  exp_t m_e;
  always @(negedge clk) begin
    if (reset_n && a_done && !done_q) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        m_e = sb.pop_front();
        chk("id_a", a_id, m_e.id);
        chk("ts_a", a_ts, m_e.ts);
        chk("id_b", b_id, m_e.id);
        chk("ts_b", b_ts, m_e.ts);
        chk("pass_a", {31'd0, a_pass}, {31'd0, m_e.pa});
        chk("pass_b", {31'd0, b_pass}, {31'd0, m_e.pb});
        chk("timeout_a", {31'd0, a_timeout}, {31'd0, m_e.to});
        chk("timeout_b", {31'd0, b_timeout}, {31'd0, m_e.to});
        chk("done_b", {31'd0, b_done}, 32'd1);
        chk("busy_at_done", {30'd0, a_busy, b_busy}, 32'd0);
        chk("read_at_done", {30'd0, a_read, b_read}, 32'd0);
      end
    end
    done_q = a_done;
  end

  task automatic launch(input int unsigned poke, output int unsigned c);
    c = 0;
    start = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #2;
      c++;
      start = (poke != 0) && (c == poke);
      if (c == 1) begin
        chk("launch_done_clr", {31'd0, a_done}, 32'd0);
        chk("launch_to_clr", {31'd0, a_timeout}, 32'd0);
        chk("launch_busy", {31'd0, a_busy}, 32'd1);
      end
      if (a_done) break;
    end
    start = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk); #2;
    end
    chk("sb_drained", sb.size(), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl_a"}, {26'd0, a_addr, a_read, a_busy, a_done, a_pass, a_timeout}, 32'd0);
    chk({tag, "_ctl_b"}, {26'd0, b_addr, b_read, b_busy, b_done, b_pass, b_timeout}, 32'd0);
    chk({tag, "_id"}, a_id | b_id, 32'd0);
    chk({tag, "_ts"}, a_ts | b_ts, 32'd0);
  endtask

  initial begin
    int unsigned c;
    reset_n = 1'b0;
    start   = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk_all_zero("reset");

    // Auto-start check after reset release
    expect_check(EXP_ID, EXP_TS, 1'b0);
    reset_n = 1'b1;
    wait_drain();

    // Nominal check: latency and address order
    acc_log.delete();
    expect_check(EXP_ID, EXP_TS, 1'b0);
    launch(0, c);
    chk("lat_nominal", c, 32'd5);
    wait_drain();
    chk("acc_count", acc_log.size(), 32'd2);
    if (acc_log.size() == 2) begin
      chk("acc_addr0", {31'd0, acc_log[0]}, 32'd0);
      chk("acc_addr1", {31'd0, acc_log[1]}, 32'd1);
    end

    // Wrong ID, with an ignored start pulse while busy
    id_data = 32'h12345678;
    expect_check(32'h12345678, EXP_TS, 1'b0);
    launch(2, c);
    chk("lat_badid", c, 32'd5);
    wait_drain();
    id_data = EXP_ID;

    // Zero timestamp: fails only where the timestamp is checked
    ts_data = 32'd0;
    expect_check(EXP_ID, 32'd0, 1'b0);
    launch(0, c);
    chk("lat_badts", c, 32'd5);
    wait_drain();
    ts_data = EXP_TS;

    // Seven stall cycles on the timestamp request
    ts_wait = 7;
    ts_req_cycles = 0;
    expect_check(EXP_ID, EXP_TS, 1'b0);
    launch(0, c);
    chk("lat_stall", c, 32'd12);
    chk("ts_req_cycles", ts_req_cycles, 32'd8);
    wait_drain();
    ts_wait = 0;

    // Slave never responds: timeout after 16 cycles, then a clean rerun
    respond = 1'b0;
    expect_check(32'd0, 32'd0, 1'b1);
    launch(0, c);
    chk("lat_timeout", c, 32'd17);
    wait_drain();
    respond = 1'b1;
    expect_check(EXP_ID, EXP_TS, 1'b0);
    launch(0, c);
    chk("lat_rerun", c, 32'd5);
    wait_drain();

    // Reset during TS_WAIT, then auto-start with a stale readdatavalid
    ts_resp = 1'b0;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (a_read && a_addr) break;
      @(posedge clk); #2;
    end
    chk("reach_ts_req", {30'd0, a_read, a_addr}, 32'd3);
    @(posedge clk); #2;
    chk("ts_wait_state", {30'd0, a_busy, a_read}, 32'd2);
    reset_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    sb.delete();
    last_id = '0;
    last_ts = '0;
    repeat (2) @(posedge clk);
    #2;
    chk_all_zero("midrst_hold");
    ts_resp = 1'b1;
    id_wait = 2;
    stale   = 1'b1;
    expect_check(EXP_ID, EXP_TS, 1'b0);
    reset_n = 1'b1;
    c = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #2;
      c++;
      if (a_done) break;
    end
    chk("lat_postrst", c, 32'd7);
    chk("stale_sent", {31'd0, stale}, 32'd0);
    wait_drain();
    id_wait = 0;

    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
